// File: rtl/caravel_freqdiv_pkg.sv
// Shared constants for the Caravel user-area frequency divider.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: pad index constants, IO_W/N_W defaults, constant io_oeb mask.
package caravel_freqdiv_pkg;

   // Default widths
   localparam int IO_W_DEF = 38;   // user-area I/O pad count
   localparam int N_W_DEF  = 4;    // divisor width

   // Pad assignment
   localparam int EN_PAD  = 0;     // divider enable
   localparam int N_PAD0  = 1;     // divisor bit 0
   localparam int N_PAD1  = 2;     // divisor bit 1
   localparam int N_PAD2  = 4;     // divisor bit 2 (pad 3 is skipped)
   localparam int N_PAD3  = 5;     // divisor bit 3
   localparam int CLK_PAD = 6;     // divider clock source at integration
   localparam int OUT_PAD = 37;    // divided clock output

   // Only the clkout pad is driven; every other pad stays an input.
   localparam logic [IO_W_DEF-1:0] OEB_MASK = ~(IO_W_DEF'(1) << OUT_PAD);

endpackage

// File: rtl/caravel_freqdiv_core.sv
// Integer clock divider: clkout period = n_act cycles, high ceil(n_act/2), low floor(n_act/2).
// Latency: 1 clk from en/n to a registered clkout.
// Backpressure: none; free-running while en=1.
// Ports: clk, rst (sync, active-high), en, n[N_W-1:0] divisor, clkout (registered).
module freqdiv_core
   import caravel_freqdiv_pkg::*;
#(
   parameter int N_W = N_W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [N_W-1:0] n,
   output logic           clkout
);

   logic [N_W-1:0] cnt;
   logic [N_W-1:0] n_act;
   logic           en_seen;     // en was high on the previous edge

   logic           start;
   logic [N_W-1:0] cnt_nxt;
   logic [N_W-1:0] n_nxt;
   logic [N_W:0]   high_len;
   logic           clkout_nxt;

   // A new period begins (and n is sampled) on the first enabled edge,
   // on every wrap, and on every edge while the divisor is unusable (<2).
   // Outside those points n is ignored, so mid-period changes wait.
   always_comb begin
      start      = 1'b0;
      cnt_nxt    = '0;
      n_nxt      = n_act;
      high_len   = '0;
      clkout_nxt = 1'b0;

      start = !en_seen || (n_act < N_W'(2)) || (cnt == n_act - N_W'(1));

      if (start) begin
         n_nxt   = n;
         cnt_nxt = '0;
      end else begin
         n_nxt   = n_act;
         cnt_nxt = cnt + N_W'(1);
      end

      // clkout is decided from the post-edge count so it can be registered
      // and still be high during the very first cycle of a period.
      high_len   = ({1'b0, n_nxt} + (N_W+1)'(1)) >> 1;
      clkout_nxt = (n_nxt >= N_W'(2)) && ({1'b0, cnt_nxt} < high_len);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         n_act   <= '0;
         en_seen <= 1'b0;
         clkout  <= 1'b0;
      end else if (!en) begin
         // Partial period is discarded; n_act is reloaded when en returns.
         cnt     <= '0;
         en_seen <= 1'b0;
         clkout  <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         n_act   <= n_nxt;
         en_seen <= 1'b1;
         clkout  <= clkout_nxt;
      end
   end

endmodule

// File: rtl/caravel_freqdiv.sv
// Caravel user-area wrapper: maps pads onto freqdiv_core, drives clkout on pad 37.
// Latency: 1 clk pad-to-pad (3 clk with CARAVEL_FREQDIV_SYNC_IN_EN defined).
// Backpressure: none.
// Ports: clk (pad 6 at integration), rst (sync, active-high), io_in/io_out/io_oeb [IO_W-1:0].
// Pads: io_in[0]=en, n={io_in[5],io_in[4],io_in[2],io_in[1]}; io_out[37]=clkout.
// Build option: define CARAVEL_FREQDIV_SYNC_IN_EN to pass en and n through 2-flop synchronizers.
module caravel_freqdiv
   import caravel_freqdiv_pkg::*;
#(
   parameter int IO_W = IO_W_DEF,
   parameter int N_W  = N_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IO_W-1:0] io_in,
   output logic [IO_W-1:0] io_out,
   output logic [IO_W-1:0] io_oeb
);

   logic           en_pad;
   logic [N_W-1:0] n_pad;
   logic           core_en;
   logic [N_W-1:0] core_n;
   logic           clkout;
   logic           unused_io;

   assign en_pad    = io_in[EN_PAD];
   assign n_pad     = N_W'({io_in[N_PAD3], io_in[N_PAD2], io_in[N_PAD1], io_in[N_PAD0]});
   // Most pads are not read by this block.
   assign unused_io = ^io_in;

`ifdef CARAVEL_FREQDIV_SYNC_IN_EN
   logic           en_s1, en_s2;
   logic [N_W-1:0] n_s1,  n_s2;

   // n is synchronized bitwise; it is only sampled at period boundaries,
   // so a transient mix of old/new bits lasts at most one reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_s1 <= 1'b0;
         en_s2 <= 1'b0;
         n_s1  <= '0;
         n_s2  <= '0;
      end else begin
         en_s1 <= en_pad;
         en_s2 <= en_s1;
         n_s1  <= n_pad;
         n_s2  <= n_s1;
      end
   end

   assign core_en = en_s2;
   assign core_n  = n_s2;
`else
   assign core_en = en_pad;
   assign core_n  = n_pad;
`endif

   freqdiv_core #(
      .N_W (N_W)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .en     (core_en),
      .n      (core_n),
      .clkout (clkout)
   );

   always_comb begin
      io_out          = '0;
      io_out[OUT_PAD] = clkout;
   end

   assign io_oeb = IO_W'(OEB_MASK);

endmodule

// File: tb/tb_caravel_freqdiv.sv
// Self-checking bench for caravel_freqdiv against a queue-based waveform model.
// Latency: model expects 1 clk (3 clk with CARAVEL_FREQDIV_SYNC_IN_EN).
// Backpressure: n/a.
module tb_caravel_freqdiv;

`ifdef CARAVEL_FREQDIV_SYNC_IN_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  n;
   logic [37:0] noise;
   logic [37:0] io_in;
   logic [37:0] io_out;
   logic [37:0] io_oeb;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: remaining output bits of the current period.
   bit          q[$];
   bit          prev_en;
   bit          exp_clk;
   bit          d_en1, d_en2;
   logic [3:0]  d_n1, d_n2;

   always #5 clk = ~clk;

   always_comb begin
      io_in    = noise;
      io_in[0] = en;
      io_in[1] = n[0];
      io_in[2] = n[1];
      io_in[4] = n[2];
      io_in[5] = n[3];
   end

   caravel_freqdiv #(
      .IO_W (38),
      .N_W  (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_in  (io_in),
      .io_out (io_out),
      .io_oeb (io_oeb)
   );

   // One clock edge of the reference: when a period begins, the whole
   // waveform for it (ceil(d/2) ones, floor(d/2) zeros) is queued.
   task automatic model_edge();
      bit         ce;
      logic [3:0] cn;
`ifdef CARAVEL_FREQDIV_SYNC_IN_EN
      ce = d_en2;
      cn = d_n2;
      if (rst) begin
         d_en1 = 0; d_en2 = 0; d_n1 = '0; d_n2 = '0;
      end else begin
         d_en2 = d_en1; d_en1 = en; d_n2 = d_n1; d_n1 = n;
      end
`else
      ce = en;
      cn = n;
`endif
      if (rst || !ce) begin
         q.delete();
         prev_en = 0;
         exp_clk = 0;
      end else begin
         if (!prev_en || q.size() == 0) begin
            if (cn >= 2) begin
               for (int i = 0; i < (int'(cn) + 1) / 2; i++) q.push_back(1'b1);
               for (int i = 0; i < int'(cn) / 2; i++)       q.push_back(1'b0);
            end
         end
         prev_en = 1;
         exp_clk = (q.size() > 0) ? q.pop_front() : 1'b0;
      end
   endtask

   task automatic step();
      noise = {6'($urandom), $urandom};
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      logic [37:0] exp_oeb;
      exp_oeb = {1'b0, {37{1'b1}}};
      rst = 1; en = 0; n = 4'($urandom);
      repeat (4) begin
         step();
         n_cmp++;
         if (io_out !== 38'd0) begin
            n_bad++; $display("FAIL reset_io_out got=%h exp=%h", io_out, 38'd0);
         end
         n_cmp++;
         if (io_oeb !== exp_oeb) begin
            n_bad++; $display("FAIL reset_io_oeb got=%h exp=%h", io_oeb, exp_oeb);
         end
      end
      rst = 0;
      step();
      n_cmp++;
      if (io_out !== 38'd0) begin
         n_bad++; $display("FAIL idle_io_out got=%h exp=%h", io_out, 38'd0);
      end
   endtask

   task automatic test_div3();
      int first_rise;
      first_rise = -1;
      en = 0; n = 3;
      repeat (3) step();
      en = 1;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (first_rise < 0 && io_out[37] === 1'b1) first_rise = k;
         n_cmp++;
         if (io_out !== {exp_clk, 37'd0}) begin
            n_bad++; $display("FAIL div3 cyc=%0d got=%h exp=%h", k, io_out, {exp_clk, 37'd0});
         end
      end
      n_cmp++;
      if (first_rise != LAT) begin
         n_bad++; $display("FAIL div3_first_rise got=%0d exp=%0d", first_rise, LAT);
      end
   endtask

   task automatic test_change_mid();
      // Running at n=3; move one cycle into a period, then switch to 4.
      step();
      n = 4;
      for (int k = 0; k < 18; k++) begin
         step();
         n_cmp++;
         if (io_out !== {exp_clk, 37'd0}) begin
            n_bad++; $display("FAIL change_mid cyc=%0d got=%h exp=%h", k, io_out, {exp_clk, 37'd0});
         end
      end
   endtask

   task automatic test_11_then_6();
      en = 0; n = 11;
      repeat (3) step();
      en = 1;
      repeat (3) step();
      n = 6;
      for (int k = 0; k < 30; k++) begin
         step();
         n_cmp++;
         if (io_out !== {exp_clk, 37'd0}) begin
            n_bad++; $display("FAIL n11_6 cyc=%0d got=%h exp=%h", k, io_out, {exp_clk, 37'd0});
         end
      end
   endtask

   task automatic test_small_n();
      en = 0; n = 1;
      repeat (3) step();
      en = 1;
      for (int k = 0; k < 20; k++) begin
         if (k == 8)  n = 0;
         if (k == 14) n = 2;
         step();
         n_cmp++;
         if (io_out !== {exp_clk, 37'd0}) begin
            n_bad++; $display("FAIL small_n cyc=%0d n=%0d got=%h exp=%h", k, n, io_out, {exp_clk, 37'd0});
         end
      end
   endtask

   task automatic test_en_drop();
      bit seen;
      seen = 0;
      en = 0; n = 6;
      repeat (3) step();
      en = 1;
      for (int k = 0; k < 20 && !seen; k++) begin
         step();
         if (io_out[37] === 1'b1) seen = 1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL en_drop_timeout got=no_high exp=high_within_20");
      end
      step();   // second cycle of the high phase
      en = 0;
      repeat (LAT) step();
      n_cmp++;
      if (io_out !== 38'd0) begin
         n_bad++; $display("FAIL en_drop got=%h exp=%h", io_out, 38'd0);
      end
      n_cmp++;
      if (io_out !== {exp_clk, 37'd0}) begin
         n_bad++; $display("FAIL en_drop_model got=%h exp=%h", io_out, {exp_clk, 37'd0});
      end
   endtask

   task automatic test_rst_mid();
      en = 1; n = 7;
      repeat (LAT + 2) step();
      rst = 1;
      step();
      n_cmp++;
      if (io_out !== 38'd0) begin
         n_bad++; $display("FAIL rst_mid got=%h exp=%h", io_out, 38'd0);
      end
      rst = 0;
      for (int k = 0; k < 16; k++) begin
         step();
         n_cmp++;
         if (io_out !== {exp_clk, 37'd0}) begin
            n_bad++; $display("FAIL rst_resume cyc=%0d got=%h exp=%h", k, io_out, {exp_clk, 37'd0});
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         rst = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 19) == 0) en = ~en;
         if ($urandom_range(0, 7) == 0)  n = 4'($urandom);
         step();
         n_cmp++;
         if (io_out !== {exp_clk, 37'd0}) begin
            n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", k, io_out, {exp_clk, 37'd0});
         end
      end
      rst = 0;
   endtask

   initial begin
      rst = 1; en = 0; n = '0; noise = '0;
      prev_en = 0; exp_clk = 0;
      d_en1 = 0; d_en2 = 0; d_n1 = '0; d_n2 = '0;
      test_reset();
      test_div3();
      test_change_mid();
      test_11_then_6();
      test_small_n();
      test_en_drop();
      test_rst_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
